mem_write_queue: RTL and testbench
==================================

MEM_WRITE_QUEUE -- requirements
Module: mem_write_queue

Interface
REQ-001 The block SHALL have parameters, one per line:
  DEPTH  4  queue entries, power of two
  DATA_W  32  data width
  ADDR_W  16  address width
REQ-002 The block SHALL have ports, one per line (name  direction  width  meaning):
  clk  input  1  single clock; all state on rising edge
  reset  input  1  asynchronous, active-high reset
  wr_valid  input  1  write request from memoryRegister stage
  wr_addr  input  ADDR_W  write address (dirrOutput)
  wr_data  input  DATA_W  write data (dataOutput)
  wr_ready  output  1  queue can accept write
  rd_valid  input  1  read request
  rd_addr  input  ADDR_W  read address
  rd_ready  output  1  read request accepted this cycle
  rd_data  output  DATA_W  registered read result
  rd_data_valid  output  1  one-cycle pulse, rd_data valid
  mem_addr  output  ADDR_W  memory address
  mem_data_out  output  DATA_W  memory write data
  mem_write  output  1  memory write strobe
  mem_data_in  input  DATA_W  memory read data, combinational from mem_addr
  count  output  $clog2(DEPTH)+1  current occupancy
REQ-003 The block SHALL have one clock domain (clk) and reset SHALL be asynchronous, active-high.

Function
REQ-004 A write SHALL be accepted on a cycle where wr_valid=1 and wr_ready=1; the entry is appended at the tail.
REQ-005 wr_ready SHALL be 1 exactly when count<DEPTH; a same-cycle pop does not raise it.
REQ-006 FSM states SHALL be IDLE, DRAIN, READ.
REQ-007 IDLE: if count>0, next state DRAIN; else if rd_valid=1, rd_ready=1, rd_addr captured, next state READ; else stay IDLE.
REQ-008 DRAIN: mem_write=1, mem_addr/mem_data_out = head entry, head popped every cycle; exit to IDLE when the entry popped is the last and no write is accepted that cycle.
REQ-009 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-010 READ: mem_write=0, mem_addr = captured address; rd_data SHALL register mem_data_in at end of cycle; rd_data_valid=1 on the following cycle only; next state IDLE.
REQ-011 Read accepted in IDLE with a same-cycle write accepted SHALL be ordered before that write.
REQ-012 rd_ready SHALL be 0 in DRAIN and READ; reads wait until queue empty (write stream may starve reads; permitted).
REQ-013 Outside DRAIN, mem_write SHALL be 0; mem_addr/mem_data_out SHALL be 0 in IDLE.
REQ-014 Head/tail pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-015 On reset: state IDLE, pointers 0, count 0, wr_ready 1, rd_ready 0, rd_data 0, rd_data_valid 0, mem_write 0, mem_addr 0, mem_data_out 0.
REQ-016 Reset mid-DRAIN or mid-READ SHALL discard queued entries and any pending read with no further memory strobe.

Structure
REQ-017 FSM state encodings and default widths SHALL live in shared package mem_pkg.
REQ-018 Queue storage and pointers SHALL be sub-module wq_fifo; FSM and memory muxing in mem_write_queue.

Verification
REQ-019 Push (0x0004, 0xACEDCAFE) -> next cycle DRAIN, mem_write=1, mem_addr=0x0004, mem_data_out=0xACEDCAFE, then IDLE, count 0.
REQ-020 Push 4 writes back-to-back with no drain opportunity blocked -> count reaches 4 only if pops stalled; fifth wr_valid sees wr_ready=0; all four drained in order.
REQ-021 Continuous push at 1/cycle during DRAIN -> count constant, mem_write stays 1, order preserved.
REQ-022 Write 0xDEADBEEF to 0x0003 then read 0x0003 -> rd_ready held 0 until drained; rd_data_valid pulses with rd_data=0xDEADBEEF.
REQ-023 Simultaneous rd_valid(0x0005) and wr_valid in empty IDLE -> READ first, write drained after rd_data_valid.
REQ-024 reset asserted with 3 entries queued -> outputs at reset values immediately, no mem_write after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory write queue: FSM encoding and default widths.
package mem_pkg;

    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_READ  = 2'd2
    } state_t;

    // Occupancy counter width: must hold the value DEPTH itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wq_fifo.sv
// Write-queue storage: circular buffer of (address, data) entries with occupancy count.
// Exposes the head entry and the entry behind it so the drain path can preload
// the next memory strobe into registers.
module wq_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_W-1:0]     push_addr,
    input  logic [DATA_W-1:0]     push_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [ADDR_W-1:0]     head_addr,
    output logic [DATA_W-1:0]     head_data,
    output logic [ADDR_W-1:0]     next_addr,
    output logic [DATA_W-1:0]     next_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_nx;

    assign head_nx   = head + PTR_W'(1);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign next_addr = addr_mem[head_nx];
    assign next_data = data_mem[head_nx];

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks push minus pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head_nx;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_write_queue.sv
// Posted-write queue in front of a single-port memory. Queued writes drain one
// per cycle; reads are only taken when the queue is empty, so a read never
// overtakes an earlier write. All outputs except the queue count are registered.
module mem_write_queue
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    input  logic                   rd_valid,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_data_valid,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data_out,
    output logic                   mem_write,
    input  logic [DATA_W-1:0]      mem_data_in,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);

    state_t            state;
    logic              push;
    logic              pop;
    logic              rd_accept;
    logic [CNT_W-1:0]  next_count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_data;

    wq_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_addr(wr_addr),
        .push_data(wr_data),
        .count    (count),
        .head_addr(head_addr),
        .head_data(head_data),
        .next_addr(next_addr),
        .next_data(next_data)
    );

    // Handshakes and the occupancy the queue will have after this edge.
    always_comb begin
        push       = wr_valid && wr_ready;
        pop        = (state == S_DRAIN);
        rd_accept  = (state == S_IDLE) && (count == '0) && rd_valid && rd_ready;
        next_count = count;
        if (push && !pop)      next_count = count + CNT_W'(1);
        else if (pop && !push) next_count = count - CNT_W'(1);
    end

    // FSM with registered memory bus; the bus value for the next cycle is
    // chosen here, including bypass of a write that refills an emptying queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            wr_ready      <= 1'b1;
            rd_ready      <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_data_out  <= '0;
        end else begin
            wr_ready      <= (next_count < CNT_W'(DEPTH));
            rd_ready      <= 1'b0;
            rd_data_valid <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_data_out  <= '0;
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state        <= S_DRAIN;
                        mem_write    <= 1'b1;
                        mem_addr     <= head_addr;
                        mem_data_out <= head_data;
                    end else if (rd_accept) begin
                        state    <= S_READ;
                        mem_addr <= rd_addr;
                    end else begin
                        rd_ready <= (next_count == '0);
                    end
                end
                S_DRAIN: begin
                    if (count == CNT_W'(1) && !push) begin
                        state    <= S_IDLE;
                        rd_ready <= 1'b1;
                    end else begin
                        mem_write <= 1'b1;
                        if (count > CNT_W'(1)) begin
                            mem_addr     <= next_addr;
                            mem_data_out <= next_data;
                        end else begin
                            mem_addr     <= wr_addr;
                            mem_data_out <= wr_data;
                        end
                    end
                end
                S_READ: begin
                    state         <= S_IDLE;
                    rd_data       <= mem_data_in;
                    rd_data_valid <= 1'b1;
                    rd_ready      <= (next_count == '0);
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_queue.sv
// Self-checking bench for mem_write_queue: directed scenarios plus a randomized
// run against a transaction-level queue model with its own memory image.
module tb_mem_write_queue;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic [15:0] mem_addr;
    logic [31:0] mem_data_out;
    logic        mem_write;
    logic [31:0] mem_data_in;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] phys [16] = '{default: 32'h0};
    logic [31:0] model_mem [16] = '{default: 32'h0};
    logic [47:0] log_q [$];

    mem_write_queue dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_addr      (rd_addr),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the queue: combinational read, write on strobe, strobe log.
    always_comb mem_data_in = phys[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_write === 1'b1) begin
            phys[mem_addr[3:0]] <= mem_data_out;
            log_q.push_back({mem_addr, mem_data_out});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        n_cmp++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
        n_cmp++; if (mem_addr !== 16'h0 || mem_data_out !== 32'h0) begin n_bad++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_data_out); end
        n_cmp++; if (rd_data !== 32'h0 || rd_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd got %h/%b want 0/0", rd_data, rd_data_valid); end
        reset = 1'b0;
        cyc();
        n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_rd_ready got %b want 1", rd_ready); end
    endtask

    task automatic test_single_write();
        wr_valid = 1'b1; wr_addr = 16'h0004; wr_data = 32'hACEDCAFE;
        cyc();
        wr_valid = 1'b0;
        n_cmp++; if (count !== 3'd1 || mem_write !== 1'b0) begin n_bad++; $display("FAIL single_queued got cnt=%0d mw=%b want 1/0", count, mem_write); end
        cyc();
        n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL single_strobe got %b want 1", mem_write); end
        n_cmp++; if (mem_addr !== 16'h0004 || mem_data_out !== 32'hACEDCAFE) begin n_bad++; $display("FAIL single_bus got %h/%h want 0004/acedcafe", mem_addr, mem_data_out); end
        cyc();
        n_cmp++; if (mem_write !== 1'b0 || count !== 3'd0 || mem_addr !== 16'h0) begin n_bad++; $display("FAIL single_done got mw=%b cnt=%0d addr=%h want 0/0/0", mem_write, count, mem_addr); end
    endtask

    task automatic test_stream();
        logic [47:0] exp_q [$];
        int k;
        log_q.delete();
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 16'(i);
            wr_data  = $urandom;
            exp_q.push_back({wr_addr, wr_data});
            n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL stream_wr_ready[%0d] got %b want 1", i, wr_ready); end
            cyc();
            if (i >= 1) begin
                n_cmp++; if (count !== 3'd2 || mem_write !== 1'b1) begin n_bad++; $display("FAIL stream_steady[%0d] got cnt=%0d mw=%b want 2/1", i, count, mem_write); end
            end
        end
        wr_valid = 1'b0;
        k = 0;
        while ((count != 3'd0 || mem_write) && k < 12) begin cyc(); k++; end
        n_cmp++; if (k >= 12) begin n_bad++; $display("FAIL stream_drain_timeout got cnt=%0d want 0", count); end
        n_cmp++; if (log_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stream_strobes got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++; if (log_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stream_order[%0d] got %h want %h", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_write_then_read();
        bit acc;
        bit seen;
        wr_valid = 1'b1; wr_addr = 16'h0003; wr_data = 32'hDEADBEEF;
        cyc();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 16'h0003;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rd_data_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (count != 3'd0 || mem_write) begin
                    n_cmp++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL wr_rd_blocked[%0d] got %b want 0", k, rd_ready); end
                end
                acc = rd_ready;
                cyc();
                if (acc) rd_valid = 1'b0;
            end
        end
        rd_valid = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL wr_rd_timeout got no rd_data_valid want pulse"); end
        n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_data got %h want deadbeef", rd_data); end
        cyc();
        n_cmp++; if (rd_data_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rd_pulse got %b want 0", rd_data_valid); end
    endtask

    task automatic test_simul_rd_wr();
        wr_valid = 1'b1; wr_addr = 16'h0005; wr_data = 32'h11112222;
        cyc();
        wr_valid = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL simul_pre_ready got %b want 1", rd_ready); end
        rd_valid = 1'b1; rd_addr = 16'h0005;
        wr_valid = 1'b1; wr_addr = 16'h0005; wr_data = 32'h33334444;
        cyc();
        rd_valid = 1'b0; wr_valid = 1'b0;
        n_cmp++; if (mem_write !== 1'b0 || mem_addr !== 16'h0005 || count !== 3'd1) begin n_bad++; $display("FAIL simul_read got mw=%b addr=%h cnt=%0d want 0/0005/1", mem_write, mem_addr, count); end
        cyc();
        n_cmp++; if (rd_data_valid !== 1'b1 || rd_data !== 32'h11112222) begin n_bad++; $display("FAIL simul_rdata got v=%b d=%h want 1/11112222", rd_data_valid, rd_data); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL simul_no_early_write got %b want 0", mem_write); end
        cyc();
        n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 16'h0005 || mem_data_out !== 32'h33334444) begin n_bad++; $display("FAIL simul_drain got mw=%b %h/%h want 1 0005/33334444", mem_write, mem_addr, mem_data_out); end
        cyc();
    endtask

    task automatic test_reset_mid();
        rd_valid = 1'b1; rd_addr = 16'h0006;
        wr_valid = 1'b1; wr_addr = 16'h0006; wr_data = 32'hA0A0A0A0;
        cyc();
        rd_valid = 1'b0; wr_addr = 16'h0007; wr_data = 32'hB0B0B0B0;
        cyc();
        wr_addr = 16'h0002; wr_data = 32'hC0C0C0C0;
        cyc();
        wr_valid = 1'b0;
        n_cmp++; if (count !== 3'd3 || mem_write !== 1'b1) begin n_bad++; $display("FAIL mid_setup got cnt=%0d mw=%b want 3/1", count, mem_write); end
        reset = 1'b1;
        #1;
        log_q.delete();
        n_cmp++; if (count !== 3'd0 || wr_ready !== 1'b1 || rd_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ctl got cnt=%0d wr=%b rd=%b want 0/1/0", count, wr_ready, rd_ready); end
        n_cmp++; if (mem_write !== 1'b0 || mem_addr !== 16'h0 || mem_data_out !== 32'h0) begin n_bad++; $display("FAIL mid_reset_bus got mw=%b %h/%h want 0 0/0", mem_write, mem_addr, mem_data_out); end
        n_cmp++; if (rd_data !== 32'h0 || rd_data_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_rd got %h/%b want 0/0", rd_data, rd_data_valid); end
        cyc();
        cyc();
        reset = 1'b0;
        repeat (6) cyc();
        n_cmp++; if (log_q.size() != 0 || count !== 3'd0) begin n_bad++; $display("FAIL mid_after_release got strobes=%0d cnt=%0d want 0/0", log_q.size(), count); end
    endtask

    task automatic test_random();
        ent_t        q [$];
        int          mode;
        bit          e_rdy;
        bit          e_rvalid;
        logic [31:0] e_rdata;
        logic [15:0] m_ra;
        logic [15:0] e_ma;
        logic [31:0] e_md;
        bit          push;
        bit          acc;
        bit          was_read;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        mode = 0; e_rdy = 1'b0; e_rvalid = 1'b0; e_rdata = 32'h0; m_ra = 16'h0;
        for (int c = 0; c < 400; c++) begin
            e_ma = (mode == 1) ? q[0].a : (mode == 2) ? m_ra : 16'h0;
            e_md = (mode == 1) ? q[0].d : 32'h0;
            n_cmp++; if (count !== 3'(q.size())) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, count, q.size()); end
            n_cmp++; if (wr_ready !== (q.size() < 4)) begin n_bad++; $display("FAIL rnd_wr_ready[%0d] got %b want %b", c, wr_ready, q.size() < 4); end
            n_cmp++; if (rd_ready !== e_rdy) begin n_bad++; $display("FAIL rnd_rd_ready[%0d] got %b want %b", c, rd_ready, e_rdy); end
            n_cmp++; if (mem_write !== (mode == 1)) begin n_bad++; $display("FAIL rnd_mem_write[%0d] got %b want %b", c, mem_write, mode == 1); end
            n_cmp++; if (mem_addr !== e_ma || mem_data_out !== e_md) begin n_bad++; $display("FAIL rnd_mem_bus[%0d] got %h/%h want %h/%h", c, mem_addr, mem_data_out, e_ma, e_md); end
            n_cmp++; if (rd_data_valid !== e_rvalid || rd_data !== e_rdata) begin n_bad++; $display("FAIL rnd_rd[%0d] got %b/%h want %b/%h", c, rd_data_valid, rd_data, e_rvalid, e_rdata); end

            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 16'(8 + $urandom_range(0, 7));
            wr_data  = $urandom;
            rd_valid = ($urandom_range(0, 3) == 0);
            rd_addr  = 16'(8 + $urandom_range(0, 7));

            push     = wr_valid && (q.size() < 4);
            acc      = rd_valid && e_rdy;
            was_read = (mode == 2);
            case (mode)
                0: begin
                    if (q.size() > 0) mode = 1;
                    else if (acc) begin mode = 2; m_ra = rd_addr; end
                end
                1: begin
                    model_mem[q[0].a[3:0]] = q[0].d;
                    void'(q.pop_front());
                end
                default: begin
                    e_rdata = model_mem[m_ra[3:0]];
                    mode = 0;
                end
            endcase
            if (push) q.push_back('{a: wr_addr, d: wr_data});
            if (mode == 1 && q.size() == 0) mode = 0;
            e_rvalid = was_read;
            e_rdy    = (mode == 0) && (q.size() == 0);
            cyc();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_addr = 16'h0; wr_data = 32'h0;
        rd_valid = 1'b0; rd_addr = 16'h0;
        test_reset();
        test_single_write();
        test_stream();
        test_write_then_read();
        test_simul_rd_wr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
